sha2_multi_core: RTL and testbench
==================================

Name: sha2_multi_core

Overview:
- Parametrised SHA-2 compression engine, the successor to the fixed SHA-512 core in the HMAC datapath.
- Runtime-selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds) per message.
- Consumes pre-padded 16-word blocks through a valid/ready word stream and produces a registered digest with a done pulse.
- Padding and length insertion live upstream in the existing pad unit.

Parameters:
- EnSha256, 1, include SHA-256 datapath; if 0, mode_i=0 is treated as SHA-512.
- EnSha512, 1, include SHA-512 datapath; if 0, mode_i=1 is treated as SHA-256; at least one must be 1 (elaboration assert).
- WIdxW, 4, width of word-load index (16 words per block); fixed, exposed for package consistency.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- sha_en_i  input  1  engine enable; low clears all state synchronously
- start_i  input  1  begin a new message; latches mode and loads IV
- mode_i  input  2  0=SHA-256, 1=SHA-512, 2=SHA-384, 3=SHA-512/256 (2,3 only with macro)
- msg_valid_i  input  1  message word valid
- msg_data_i  input  64  message word; SHA-256 uses [31:0], upper bits ignored
- msg_last_i  input  1  marks final word of final block; sampled with word 15 only
- msg_ready_o  output  1  word accepted when valid&&ready
- busy_o  output  1  high from start_i until done_o
- done_o  output  1  one-cycle pulse, digest final
- digest_o  output  512  H0 in [511:448] … H7 in [63:0]; SHA-256 words zero-extended per 64-bit lane

Behaviour:
- Reset: digest_o=0, done_o=0, busy_o=0, msg_ready_o=0, FSM=Idle, round=0, word index=0.
- Key FSM (mode register latched on start_i):
  - Idle: msg_ready_o=0. start_i loads the IV for the latched mode into digest; go to Load.
  - Load: msg_ready_o=1. Each accepted word shifts into W[15] and increments the index. Word 15 accepted → record last flag, go to Compress; hash regs ← digest the same cycle.
  - Compress: one round per cycle, 64 (SHA-256) or 80 (SHA-512 family). W recomputed with the mode's sigma functions while round < NR-16; zero-shifted afterwards. msg_ready_o=0.
  - Update: digest[i] ← digest[i]+hash[i], mod 2^32 or 2^64 per mode. If last flag → Done, else → Load.
  - Done: done_o=1 for exactly one cycle (registered), busy_o drops the same cycle, → Idle.
- Latency per block: 16 load cycles (no stalls) + NR compress + 1 update. First block: done 1 cycle after the final update.
- Backpressure: msg_valid_i low during Load stalls with no state change; an incomplete block never starts compression.
- start_i outside Idle: ignored. sha_en_i low in any state: FSM→Idle, digest/W/round/index cleared next cycle, no done_o.
- msg_last_i on words 0-14: ignored.
- SHA-256 arithmetic: 32-bit only; upper lane bits forced to 0 in W, hash and digest (no carry leakage).
- Round constants: shared table; SHA-256 uses the upper 32 bits of the first 64 SHA-512 constants.
- digest_o holds its value after done_o until the next start_i or sha_en_i deassertion.

Optional Feature:
- SHA2_TRUNC_MODES_EN defined: mode_i 2 (SHA-384) and 3 (SHA-512/256) select their own IVs and use the 80-round 64-bit datapath. digest_o is masked to the truncated width: SHA-384 words H6,H7=0; SHA-512/256 words H4..H7=0.
- Undefined: modes 2,3 alias to SHA-512 (mode 1) and no extra IV ROM is built.

Decomposition:
- Shared package sha2_pkg: sha2_mode_e, sha_word_t (64-bit), 80-entry K512 constant array, IV arrays per mode, NumRound256=64, NumRound512=80, compress/calc_w functions parametrised by mode.
- One sub-module: sha2_round — combinational one-round step plus W-schedule update selected by mode, instantiated once.

Test Plan:
- SHA-256 "abc" single padded block, no stalls → done_o after 16+64+2 cycles from first word; digest lanes = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- SHA-512 "abc" padded block with msg_valid_i randomly deasserted 30% → digest H0=ddaf35a193617aba, H7=a54ca49f; done_o exactly one pulse.
- SHA-256 two-block NIST message "abcdbcdecdef…nopq" (msg_last_i on block 2 only) → 248d6a61 d20638b8 … 19db06c1; no done_o after block 1.
- sha_en_i dropped at round 40 of SHA-512 → no done_o, digest_o=0 next cycle; fresh start_i then yields the correct "abc" digest.
- SHA2_TRUNC_MODES_EN, mode 2, "abc" → H0=cb00753f45a35e8b, H5=58baeca134c825a7, H6=H7=0; without macro, same stimulus gives the SHA-512 result.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 types, round constants, initial values and round/schedule functions.
// SHA2_TRUNC_MODES_EN adds the SHA-384 and SHA-512/256 initial values.
package sha2_pkg;

  typedef enum logic [1:0] {
    Sha256     = 2'd0,
    Sha512     = 2'd1,
    Sha384     = 2'd2,
    Sha512_256 = 2'd3
  } sha2_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompress,
    StUpdate,
    StDone
  } sha2_state_e;

  typedef logic [63:0] sha_word_t;
  // Element 7 is a/H0 (top of digest_o), element 0 is h/H7.
  typedef logic [7:0][63:0] sha_state_t;
  // Element 0 is the word consumed this round, element 15 the newest.
  typedef logic [15:0][63:0] sha_sched_t;

  localparam int unsigned NumRound256 = 64;
  localparam int unsigned NumRound512 = 80;

  localparam sha_word_t K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam sha_state_t IV256 = {
    64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
    64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19
  };

  localparam sha_state_t IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

`ifdef SHA2_TRUNC_MODES_EN
  localparam sha_state_t IV384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  localparam sha_state_t IV512_256 = {
    64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
    64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2
  };
`endif

  function automatic sha_state_t iv_of(sha2_mode_e mode);
    sha_state_t iv;
    case (mode)
      Sha256:     iv = IV256;
`ifdef SHA2_TRUNC_MODES_EN
      Sha384:     iv = IV384;
      Sha512_256: iv = IV512_256;
`endif
      default:    iv = IV512;
    endcase
    return iv;
  endfunction

  function automatic logic [31:0] rotr32(logic [31:0] x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sha_word_t rotr64(sha_word_t x, int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // SHA-256 keeps the upper lane at zero so no carry can leak upward.
  function automatic sha_word_t mask_word(sha_word_t x, logic is_256);
    return is_256 ? {32'h0, x[31:0]} : x;
  endfunction

  function automatic sha_word_t big_sigma0(sha_word_t x, logic is_256);
    if (is_256) return {32'h0, rotr32(x[31:0], 2) ^ rotr32(x[31:0], 13) ^ rotr32(x[31:0], 22)};
    return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
  endfunction

  function automatic sha_word_t big_sigma1(sha_word_t x, logic is_256);
    if (is_256) return {32'h0, rotr32(x[31:0], 6) ^ rotr32(x[31:0], 11) ^ rotr32(x[31:0], 25)};
    return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
  endfunction

  function automatic sha_word_t small_sigma0(sha_word_t x, logic is_256);
    if (is_256) return {32'h0, rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3)};
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic sha_word_t small_sigma1(sha_word_t x, logic is_256);
    if (is_256) return {32'h0, rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10)};
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  function automatic sha_state_t compress(sha_state_t s, sha_word_t k, sha_word_t wt,
                                          logic is_256);
    sha_word_t t1;
    sha_word_t t2;
    sha_word_t ch;
    sha_word_t maj;
    ch  = (s[3] & s[2]) ^ (~s[3] & s[1]);
    maj = (s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]);
    t1  = s[0] + big_sigma1(s[3], is_256) + ch + k + wt;
    t2  = big_sigma0(s[7], is_256) + maj;
    return {mask_word(t1 + t2, is_256), s[7], s[6], s[5],
            mask_word(s[4] + t1, is_256), s[3], s[2], s[1]};
  endfunction

  function automatic sha_sched_t calc_w(sha_sched_t w, logic is_256, logic sched_en);
    sha_word_t nw;
    nw = sched_en ? mask_word(small_sigma1(w[14], is_256) + w[9] +
                              small_sigma0(w[1], is_256) + w[0], is_256) : '0;
    return {nw, w[15:1]};
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One SHA-2 compression round plus message-schedule step for the selected word width.
module sha2_round
  import sha2_pkg::*;
(
  input  logic          is_256,
  input  logic [6:0]    round_idx,
  input  logic [511:0]  hash_cur,
  input  logic [1023:0] w_cur,
  output logic [511:0]  hash_next,
  output logic [1023:0] w_next
);

  sha_state_t hash_s;
  sha_sched_t w_s;
  sha_word_t  k_word;
  logic       sched_en;

  assign hash_s = hash_cur;
  assign w_s    = w_cur;

  // SHA-256 constants are the upper halves of the first 64 SHA-512 ones.
  assign k_word   = is_256 ? {32'h0, K512[round_idx][63:32]} : K512[round_idx];
  assign sched_en = is_256 ? (round_idx < 7'(NumRound256 - 16))
                           : (round_idx < 7'(NumRound512 - 16));

  assign hash_next = compress(hash_s, k_word, w_s[0], is_256);
  assign w_next    = calc_w(w_s, is_256, sched_en);

endmodule

// File: rtl/sha2_multi_core.sv
// Runtime-selectable SHA-256/SHA-512 compression engine fed by a 16-word block stream.
// Define SHA2_TRUNC_MODES_EN to add SHA-384 and SHA-512/256 (modes 2 and 3).
module sha2_multi_core
  import sha2_pkg::*;
#(
  parameter bit          EnSha256 = 1'b1,
  parameter bit          EnSha512 = 1'b1,
  parameter int unsigned WIdxW    = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sha_en_i,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic         msg_valid_i,
  input  logic [63:0]  msg_data_i,
  input  logic         msg_last_i,
  output logic         msg_ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [511:0] digest_o
);

  if (!EnSha256 && !EnSha512) begin : g_cfg_check
    $error("sha2_multi_core: at least one of EnSha256/EnSha512 must be set");
  end

  sha2_state_e        state_reg, state_next;
  sha2_mode_e         mode_reg, mode_next;
  sha_state_t         digest_reg, digest_next;
  sha_state_t         hash_reg, hash_next;
  sha_sched_t         w_reg, w_next;
  logic [6:0]         round_reg, round_next;
  logic [WIdxW-1:0]   widx_reg, widx_next;
  logic               last_reg, last_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;

  sha2_mode_e         start_mode;
  logic               is_256;
  logic [6:0]         last_round;
  logic [511:0]       round_hash;
  logic [1023:0]      round_w;
  sha_state_t         upd_digest;

  function automatic sha2_mode_e resolve_mode(logic [1:0] m);
    sha2_mode_e r;
    case (m)
      2'd0:    r = Sha256;
      2'd1:    r = Sha512;
`ifdef SHA2_TRUNC_MODES_EN
      2'd2:    r = Sha384;
      default: r = Sha512_256;
`else
      default: r = Sha512;
`endif
    endcase
    if (!EnSha512) r = Sha256;
    else if (!EnSha256 && r == Sha256) r = Sha512;
    return r;
  endfunction

  assign start_mode = resolve_mode(mode_i);
  assign is_256     = !EnSha512 || (EnSha256 && (mode_reg == Sha256));
  assign last_round = is_256 ? 7'(NumRound256 - 1) : 7'(NumRound512 - 1);

  sha2_round u_round (
    .is_256    (is_256),
    .round_idx (round_reg),
    .hash_cur  (hash_reg),
    .w_cur     (w_reg),
    .hash_next (round_hash),
    .w_next    (round_w)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign upd_digest[gi] = mask_word(digest_reg[gi] + hash_reg[gi], is_256);
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    digest_next = digest_reg;
    hash_next   = hash_reg;
    w_next      = w_reg;
    round_next  = round_reg;
    widx_next   = widx_reg;
    last_next   = last_reg;
    done_next   = 1'b0;
    busy_next   = busy_reg;
    if (!sha_en_i) begin
      state_next  = StIdle;
      mode_next   = Sha256;
      digest_next = '0;
      hash_next   = '0;
      w_next      = '0;
      round_next  = '0;
      widx_next   = '0;
      last_next   = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        StIdle: begin
          if (start_i) begin
            mode_next   = start_mode;
            digest_next = iv_of(start_mode);
            round_next  = '0;
            widx_next   = '0;
            last_next   = 1'b0;
            busy_next   = 1'b1;
            state_next  = StLoad;
          end
        end
        StLoad: begin
          if (msg_valid_i) begin
            w_next    = {mask_word(msg_data_i, is_256), w_reg[15:1]};
            widx_next = widx_reg + 1'b1;
            // The last flag only counts when it arrives with word 15.
            if (&widx_reg) begin
              last_next  = msg_last_i;
              hash_next  = digest_reg;
              round_next = '0;
              state_next = StCompress;
            end
          end
        end
        StCompress: begin
          hash_next = round_hash;
          w_next    = round_w;
          if (round_reg == last_round) begin
            round_next = '0;
            state_next = StUpdate;
          end else begin
            round_next = round_reg + 7'd1;
          end
        end
        StUpdate: begin
          digest_next = upd_digest;
          if (last_reg) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = StDone;
          end else begin
            state_next = StLoad;
          end
        end
        StDone:  state_next = StIdle;
        default: state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= StIdle;
      mode_reg   <= Sha256;
      digest_reg <= '0;
      hash_reg   <= '0;
      w_reg      <= '0;
      round_reg  <= '0;
      widx_reg   <= '0;
      last_reg   <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      digest_reg <= digest_next;
      hash_reg   <= hash_next;
      w_reg      <= w_next;
      round_reg  <= round_next;
      widx_reg   <= widx_next;
      last_reg   <= last_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
    end
  end

  assign msg_ready_o = sha_en_i && (state_reg == StLoad);
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

`ifdef SHA2_TRUNC_MODES_EN
  // Truncated modes keep the full state internally and hide the dropped words.
  always_comb begin
    digest_o = digest_reg;
    if (mode_reg == Sha384) digest_o[127:0] = '0;
    else if (mode_reg == Sha512_256) digest_o[255:0] = '0;
  end
`else
  assign digest_o = digest_reg;
`endif

endmodule

// File: tb/tb_sha2_multi_core.sv
// Directed bench for sha2_multi_core using known SHA-2 test vectors.
module tb_sha2_multi_core;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         sha_en_i;
  logic         start_i;
  logic [1:0]   mode_i;
  logic         msg_valid_i;
  logic [63:0]  msg_data_i;
  logic         msg_last_i;
  logic         msg_ready_o;
  logic         busy_o;
  logic         done_o;
  logic [511:0] digest_o;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk_i = ~clk_i;

  sha2_multi_core #(.EnSha256(1'b1), .EnSha512(1'b1), .WIdxW(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sha_en_i    (sha_en_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .msg_valid_i (msg_valid_i),
    .msg_data_i  (msg_data_i),
    .msg_last_i  (msg_last_i),
    .msg_ready_o (msg_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .digest_o    (digest_o)
  );

  localparam logic [255:0] D256_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D256_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] D512_ABC = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [511:0] D384_ABC = {
    64'hcb00753f45a35e8b, 64'hb5a03d699ac65007, 64'h272c32ab0eded163, 64'h1a8b605a43ff5bed,
    64'h8086072ba1e7cc23, 64'h58baeca134c825a7, 64'h0, 64'h0};

  function automatic logic [511:0] lanes256(input logic [255:0] d);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = {32'h0, d[32*i +: 32]};
    return r;
  endfunction

  function automatic logic [15:0][63:0] abc_block(input bit is512);
    logic [15:0][63:0] b;
    b     = '0;
    b[0]  = is512 ? 64'h6162638000000000 : 64'h61626380;
    b[15] = 64'h18;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    mode_i  = m;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Called just after a negedge; returns just after the negedge following word 15's edge.
  task automatic send_block(input logic [15:0][63:0] blk, input logic last, input logic early_last,
                            input int stall_pct, input bit junk_upper, output int dones);
    int  i;
    int  guard;
    logic acc;
    i = 0; guard = 0; dones = 0;
    while (i < 16 && guard < 2000) begin
      msg_valid_i = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      msg_data_i  = junk_upper ? {$urandom, blk[i][31:0]} : blk[i];
      msg_last_i  = (i == 15) ? last : early_last;
      acc = msg_valid_i && msg_ready_o;
      @(negedge clk_i);
      if (done_o === 1'b1) dones++;
      if (acc) i++;
      guard++;
    end
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
    chk("block_accepted", 512'(i), 512'(16));
  endtask

  task automatic wait_done(input int budget, output int first, output int pulses,
                           output logic busy_at_done);
    first = -1; pulses = 0; busy_at_done = 1'bx;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first        = c;
          busy_at_done = busy_o;
        end
      end
      if (first >= 0 && c >= first + 4) break;
    end
  endtask

  initial begin
    logic [15:0][63:0] blk1;
    logic [15:0][63:0] blk2;
    int   dones, first, pulses;
    logic busy_d;
    logic [511:0] exp_trunc;

    rst_ni = 1'b0; sha_en_i = 1'b1; start_i = 1'b0; mode_i = 2'd0;
    msg_valid_i = 1'b0; msg_data_i = '0; msg_last_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_digest", digest_o, '0);
    chk("rst_done", 512'(done_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_ready", 512'(msg_ready_o), 512'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 512'(msg_ready_o), 512'(0));

    // SHA-256 "abc", no stalls, garbage in the ignored upper lane.
    do_start(2'd0);
    chk("t1_ready_load", 512'(msg_ready_o), 512'(1));
    chk("t1_busy", 512'(busy_o), 512'(1));
    send_block(abc_block(1'b0), 1'b1, 1'b0, 0, 1'b1, dones);
    wait_done(300, first, pulses, busy_d);
    // Done follows word 15's edge by 64 rounds plus the update cycle.
    chk("t1_latency", 512'(first), 512'(65));
    chk("t1_pulses", 512'(pulses), 512'(1));
    chk("t1_busy_at_done", 512'(busy_d), 512'(0));
    chk("t1_digest", digest_o, lanes256(D256_ABC));
    $display("txn t1 sha256 abc: latency=%0d pulses=%0d", first, pulses);
    repeat (5) @(negedge clk_i);
    chk("t1_digest_hold", digest_o, lanes256(D256_ABC));
    chk("t1_idle_ready", 512'(msg_ready_o), 512'(0));

    // SHA-512 "abc" with ~30% valid gaps.
    do_start(2'd1);
    send_block(abc_block(1'b1), 1'b1, 1'b0, 30, 1'b0, dones);
    wait_done(300, first, pulses, busy_d);
    chk("t2_latency", 512'(first), 512'(81));
    chk("t2_pulses", 512'(pulses), 512'(1));
    chk("t2_digest", digest_o, D512_ABC);
    $display("txn t2 sha512 abc stalled: pulses=%0d", pulses);

    // SHA-256 two-block message; last asserted early on block 1 must be ignored.
    blk1 = {64'h0, 64'h80000000, 64'h6e6f7071, 64'h6d6e6f70, 64'h6c6d6e6f, 64'h6b6c6d6e,
            64'h6a6b6c6d, 64'h696a6b6c, 64'h68696a6b, 64'h6768696a, 64'h66676869,
            64'h65666768, 64'h64656667, 64'h63646566, 64'h62636465, 64'h61626364};
    blk2 = '0;
    blk2[15] = 64'h1c0;
    do_start(2'd0);
    send_block(blk1, 1'b0, 1'b1, 0, 1'b0, dones);
    send_block(blk2, 1'b1, 1'b0, 20, 1'b0, dones);
    chk("t3_no_done_block1", 512'(dones), 512'(0));
    wait_done(300, first, pulses, busy_d);
    chk("t3_pulses", 512'(pulses), 512'(1));
    chk("t3_digest", digest_o, lanes256(D256_TWO));
    $display("txn t3 sha256 two-block: pulses=%0d", pulses);

    // start_i during compression is ignored.
    do_start(2'd0);
    send_block(abc_block(1'b0), 1'b1, 1'b0, 0, 1'b0, dones);
    repeat (10) @(negedge clk_i);
    do_start(2'd1);
    wait_done(300, first, pulses, busy_d);
    chk("t4_latency", 512'(first), 512'(54));
    chk("t4_digest", digest_o, lanes256(D256_ABC));
    $display("txn t4 start ignored: latency=%0d", first);

    // Enable dropped at round 40 of SHA-512.
    do_start(2'd1);
    send_block(abc_block(1'b1), 1'b1, 1'b0, 0, 1'b0, dones);
    repeat (40) @(negedge clk_i);
    sha_en_i = 1'b0;
    @(negedge clk_i);
    chk("t5_digest_cleared", digest_o, '0);
    chk("t5_busy_cleared", 512'(busy_o), 512'(0));
    sha_en_i = 1'b1;
    wait_done(120, first, pulses, busy_d);
    chk("t5_no_done", 512'(pulses), 512'(0));
    do_start(2'd1);
    send_block(abc_block(1'b1), 1'b1, 1'b0, 0, 1'b0, dones);
    wait_done(300, first, pulses, busy_d);
    chk("t5_restart_digest", digest_o, D512_ABC);
    $display("txn t5 enable drop then restart: pulses=%0d", pulses);

    // Mode 2: SHA-384 when truncated modes are built, otherwise SHA-512.
`ifdef SHA2_TRUNC_MODES_EN
    exp_trunc = D384_ABC;
`else
    exp_trunc = D512_ABC;
`endif
    do_start(2'd2);
    send_block(abc_block(1'b1), 1'b1, 1'b0, 0, 1'b0, dones);
    wait_done(300, first, pulses, busy_d);
    chk("t6_pulses", 512'(pulses), 512'(1));
    chk("t6_digest", digest_o, exp_trunc);
    $display("txn t6 mode2 abc: pulses=%0d", pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
